// File: rtl/crop_pkg.sv
`default_nettype none
// ============================================================================
// Module : crop_pkg
// Desc   : Shared FSM state type and counter-width helpers for the ROI cropper.
// Rev    : 1.0
// ============================================================================
package crop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int calc_cw(input int max_cols);
        return $clog2(max_cols + 1);
    endfunction

    function automatic int calc_rw(input int max_rows);
        return $clog2(max_rows + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/roi_crop_engine_if.sv
`default_nettype none
// ============================================================================
// Module : roi_crop_engine_if
// Desc   : AXI4-Stream style pixel bus used on both sides of the cropper.
// Rev    : 1.0
// ============================================================================
interface roi_crop_engine_if #(
    parameter int DATA_W = 40,
    parameter int USER_W = 2
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;

    modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module : axis_skid_buffer
// Desc   : Two-entry registered skid buffer; output held stable while stalled.
// Rev    : 1.0
// ============================================================================
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  empty
);
    logic                  r_out_valid;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  w_accept;

    // Ready depends only on registered state, so upstream sees no comb path from m_ready.
    assign s_ready  = !r_skid_valid;
    assign w_accept = s_valid && s_ready;
    assign m_valid  = r_out_valid;
    assign m_data   = r_out_data;
    assign empty    = !r_out_valid && !r_skid_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else if (!r_out_valid || m_ready) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out_data <= s_data;
                end
            end
        end else if (w_accept) begin
            r_skid_data  <= s_data;
            r_skid_valid <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/roi_crop_engine.sv
`default_nettype none
// ============================================================================
// Module : roi_crop_engine
// Desc   : Crops a rectangular region of interest out of a pixel stream.
// Rev    : 1.0
// ============================================================================
module roi_crop_engine
    import crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int PIXELS_PER_BEAT = 4,
    parameter int USER_WIDTH      = 2,
    parameter int MAX_COLS        = 4096,
    parameter int MAX_ROWS        = 3072,
    localparam int CW = calc_cw(MAX_COLS),
    localparam int RW = calc_rw(MAX_ROWS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ap_start,
    output logic                       ap_idle,
    output logic                       ap_done,
    output logic                       cfg_err,
    output logic                       sync_err,
    input  logic [CW-1:0]              cfg_in_cols,
    input  logic [CW-1:0]              cfg_x0,
    input  logic [CW-1:0]              cfg_w,
    input  logic [RW-1:0]              cfg_in_rows,
    input  logic [RW-1:0]              cfg_y0,
    input  logic [RW-1:0]              cfg_h,
    roi_crop_engine_if.slave           s_axis,
    roi_crop_engine_if.master          m_axis,
    output logic [PIXEL_BIT_WIDTH-1:0] max_value
);
    localparam int            c_DW   = PIXELS_PER_BEAT * PIXEL_BIT_WIDTH;
    localparam int            c_SW   = c_DW + 1 + USER_WIDTH;
    localparam logic [CW-1:0] c_PPB  = CW'(PIXELS_PER_BEAT);

    state_t                       r_state;
    logic                         r_ap_idle, r_ap_done, r_cfg_err, r_sync_err;
    logic [CW-1:0]                r_in_cols, r_x0, r_w, r_col;
    logic [RW-1:0]                r_in_rows, r_y0, r_h, r_row;
    logic [PIXEL_BIT_WIDTH-1:0]   r_max_value;

    logic                         w_cfg_ok, w_accept, w_sof_restart, w_in_crop, w_fwd;
    logic                         w_row_end, w_frame_end, w_tlast, w_tsof;
    logic [CW-1:0]                w_col, w_col_next;
    logic [RW-1:0]                w_row;
    logic [USER_WIDTH-1:0]        w_tuser;
    logic [PIXEL_BIT_WIDTH-1:0]   w_beat_max;
    logic                         w_skid_ready, w_skid_empty, w_skid_valid;
    logic [c_SW-1:0]              w_skid_out;

    assign w_cfg_ok = (cfg_w != '0) && (cfg_h != '0)
                   && (({1'b0, cfg_x0} + {1'b0, cfg_w}) <= {1'b0, cfg_in_cols})
                   && (({1'b0, cfg_y0} + {1'b0, cfg_h}) <= {1'b0, cfg_in_rows})
                   && (cfg_in_rows <= RW'(MAX_ROWS)) && (cfg_in_cols <= CW'(MAX_COLS))
                   && ((cfg_in_cols % c_PPB) == '0) && ((cfg_x0 % c_PPB) == '0)
                   && ((cfg_w % c_PPB) == '0);

    assign s_axis.tready = (r_state == ST_RUN) && w_skid_ready;
    assign w_accept      = s_axis.tvalid && s_axis.tready;

    // A stray SOF re-anchors the raster: that beat becomes pixel (0,0).
    assign w_sof_restart = s_axis.tuser[0] && ((r_row != '0) || (r_col != '0));
    assign w_col         = w_sof_restart ? '0 : r_col;
    assign w_row         = w_sof_restart ? '0 : r_row;
    assign w_col_next    = w_col + c_PPB;
    assign w_row_end     = (w_col_next == r_in_cols);
    assign w_frame_end   = w_row_end && (w_row == (r_in_rows - 1'b1));

    assign w_in_crop = (w_row >= r_y0) && ({1'b0, w_row} < ({1'b0, r_y0} + {1'b0, r_h}))
                    && (w_col >= r_x0) && ({1'b0, w_col} < ({1'b0, r_x0} + {1'b0, r_w}));
    assign w_fwd     = w_accept && w_in_crop;
    assign w_tlast   = ({1'b0, w_col_next} == ({1'b0, r_x0} + {1'b0, r_w}));
    assign w_tsof    = (w_row == r_y0) && (w_col == r_x0);

    always_comb begin
        w_tuser    = s_axis.tuser;
        w_tuser[0] = w_tsof;
    end

    always_comb begin
        w_beat_max = '0;
        for (int k = 0; k < PIXELS_PER_BEAT; k++) begin
            if (s_axis.tdata[k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] > w_beat_max) begin
                w_beat_max = s_axis.tdata[k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ap_idle   <= 1'b1;
            r_ap_done   <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_sync_err  <= 1'b0;
            r_in_cols   <= '0;
            r_x0        <= '0;
            r_w         <= '0;
            r_in_rows   <= '0;
            r_y0        <= '0;
            r_h         <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_max_value <= '0;
        end else begin
            r_ap_done <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        if (w_cfg_ok) begin
                            r_in_cols   <= cfg_in_cols;
                            r_x0        <= cfg_x0;
                            r_w         <= cfg_w;
                            r_in_rows   <= cfg_in_rows;
                            r_y0        <= cfg_y0;
                            r_h         <= cfg_h;
                            r_col       <= '0;
                            r_row       <= '0;
                            r_max_value <= '0;
                            r_sync_err  <= 1'b0;
                            r_ap_idle   <= 1'b0;
                            r_state     <= ST_RUN;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_sof_restart) begin
                            r_sync_err <= 1'b1;
                        end
                        if (w_fwd && (w_beat_max > r_max_value)) begin
                            r_max_value <= w_beat_max;
                        end
                        if (w_frame_end) begin
                            r_col   <= '0;
                            r_row   <= '0;
                            r_state <= ST_DRAIN;
                        end else if (w_row_end) begin
                            r_col <= '0;
                            r_row <= w_row + 1'b1;
                        end else begin
                            r_col <= w_col_next;
                            r_row <= w_row;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_skid_empty) begin
                        r_ap_idle <= 1'b1;
                        r_ap_done <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_ap_idle <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    axis_skid_buffer #(
        .DATA_WIDTH (c_SW)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .s_valid (w_fwd),
        .s_ready (w_skid_ready),
        .s_data  ({w_tuser, w_tlast, s_axis.tdata}),
        .m_valid (w_skid_valid),
        .m_ready (m_axis.tready),
        .m_data  (w_skid_out),
        .empty   (w_skid_empty)
    );

    assign m_axis.tvalid = w_skid_valid;
    assign m_axis.tdata  = w_skid_out[c_DW-1:0];
    assign m_axis.tlast  = w_skid_out[c_DW];
    assign m_axis.tuser  = w_skid_out[c_DW+1 +: USER_WIDTH];

    assign ap_idle   = r_ap_idle;
    assign ap_done   = r_ap_done;
    assign cfg_err   = r_cfg_err;
    assign sync_err  = r_sync_err;
    assign max_value = r_max_value;
endmodule
`default_nettype wire

// File: tb/tb_roi_crop_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_roi_crop_engine
// Desc   : Randomised self-checking bench against a raster-position reference model.
// Rev    : 1.0
// ============================================================================
module tb_roi_crop_engine;
    localparam int PBW = 10;
    localparam int PPB = 4;
    localparam int UW  = 2;
    localparam int DW  = PBW * PPB;
    localparam int CW  = $clog2(4096 + 1);
    localparam int RW  = $clog2(3072 + 1);

    logic           clk, reset, ap_start;
    logic           ap_idle, ap_done, cfg_err, sync_err;
    logic [CW-1:0]  cfg_in_cols, cfg_x0, cfg_w;
    logic [RW-1:0]  cfg_in_rows, cfg_y0, cfg_h;
    logic [PBW-1:0] max_value;

    roi_crop_engine_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
    roi_crop_engine_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

    roi_crop_engine #(
        .PIXEL_BIT_WIDTH (PBW),
        .PIXELS_PER_BEAT (PPB),
        .USER_WIDTH      (UW),
        .MAX_COLS        (4096),
        .MAX_ROWS        (3072)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ap_start    (ap_start),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .cfg_err     (cfg_err),
        .sync_err    (sync_err),
        .cfg_in_cols (cfg_in_cols),
        .cfg_x0      (cfg_x0),
        .cfg_w       (cfg_w),
        .cfg_in_rows (cfg_in_rows),
        .cfg_y0      (cfg_y0),
        .cfg_h       (cfg_h),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .max_value   (max_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stimulus and reference state
    logic [DW-1:0]    in_data[$];
    logic [UW-1:0]    in_user[$];
    logic [DW+UW:0]   exp_q[$];
    logic [PBW-1:0]   exp_max;
    logic             exp_sync;
    int               frame_len, sent_idx, done_count, out_count;
    int               stall_pct, gap_pct;
    logic             s_fire, held_stall;
    logic [DW+UW:0]   held_val;

    // Reference: every beat has a linear raster offset since the last frame anchor.
    task automatic compute_expected(input int cols, rows, x0, y0, w, h);
        int seg, off, r, c;
        logic [DW+UW:0] e;
        exp_q.delete();
        exp_max   = '0;
        exp_sync  = 1'b0;
        frame_len = in_data.size();
        seg       = 0;
        for (int j = 0; j < in_data.size(); j++) begin
            off = (j - seg) * PPB;
            if (in_user[j][0] && off != 0) begin
                exp_sync = 1'b1;
                seg      = j;
                off      = 0;
            end
            r = off / cols;
            c = off % cols;
            if (r >= y0 && r < y0 + h && c >= x0 && c < x0 + w) begin
                e = {in_user[j][1], (r == y0 && c == x0), (c + PPB == x0 + w), in_data[j]};
                exp_q.push_back(e);
                for (int k = 0; k < PPB; k++)
                    if (in_data[j][k*PBW +: PBW] > exp_max) exp_max = in_data[j][k*PBW +: PBW];
            end
            if (off + PPB == cols * rows) begin
                frame_len = j + 1;
                break;
            end
        end
    endtask

    task automatic build_frame(input int nbeats, input int kind);
        logic [DW-1:0] d;
        in_data.delete();
        in_user.delete();
        for (int j = 0; j < nbeats; j++) begin
            for (int k = 0; k < PPB; k++) begin
                if (kind == 0)      d[k*PBW +: PBW] = PBW'((j * PPB + k) % 1024);
                else if (kind == 1) d[k*PBW +: PBW] = PBW'($urandom_range(0, 1023));
                else                d[k*PBW +: PBW] = PBW'($urandom_range(0, 99));
            end
            in_data.push_back(d);
            in_user.push_back({1'($urandom_range(0, 1)), (j == 0)});
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (s_fire) begin
            sent_idx++;
            s_if.tvalid = 1'b0;
        end
        m_if.tready = ($urandom_range(0, 99) >= stall_pct);
        if (!s_if.tvalid && sent_idx < frame_len && $urandom_range(0, 99) >= gap_pct) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = in_data[sent_idx];
            s_if.tuser  = in_user[sent_idx];
        end
        #1;
        if (held_stall) begin
            check("stall_valid", 64'(m_if.tvalid), 64'd1);
            check("stall_data", 64'({m_if.tuser, m_if.tlast, m_if.tdata}), 64'(held_val));
        end
        held_stall = m_if.tvalid && !m_if.tready;
        held_val   = {m_if.tuser, m_if.tlast, m_if.tdata};
        if (m_if.tvalid && m_if.tready) begin
            out_count++;
            if (exp_q.size() == 0) check("extra_beat", 64'd1, 64'd0);
            else check("beat", 64'({m_if.tuser, m_if.tlast, m_if.tdata}), 64'(exp_q.pop_front()));
        end
        if (ap_done) done_count++;
        s_fire = s_if.tvalid && s_if.tready;
    endtask

    task automatic start_frame(input int cols, rows, x0, y0, w, h);
        @(negedge clk);
        cfg_in_cols = CW'(cols);
        cfg_in_rows = RW'(rows);
        cfg_x0      = CW'(x0);
        cfg_y0      = RW'(y0);
        cfg_w       = CW'(w);
        cfg_h       = RW'(h);
        ap_start    = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        // Corrupt the cfg inputs: the latched copy must be the one in use.
        cfg_x0 = CW'(2);
        cfg_w  = '0;
        cfg_y0 = '0;
        #1;
        check("start_idle", 64'(ap_idle), 64'd0);
        check("start_max_clear", 64'(max_value), 64'd0);
        check("start_sync_clear", 64'(sync_err), 64'd0);
    endtask

    task automatic run_frame(input int cols, rows, x0, y0, w, h, stall, gap);
        int n_exp;
        compute_expected(cols, rows, x0, y0, w, h);
        n_exp      = exp_q.size();
        stall_pct  = stall;
        gap_pct    = gap;
        sent_idx   = 0;
        done_count = 0;
        out_count  = 0;
        s_fire     = 1'b0;
        held_stall = 1'b0;
        start_frame(cols, rows, x0, y0, w, h);
        for (int cyc = 0; cyc < 3000 && done_count == 0; cyc++) step();
        if (done_count == 0) check("done_timeout", 64'd0, 64'd1);
        repeat (3) step();
        check("done_pulses", 64'(done_count), 64'd1);
        check("beats_consumed", 64'(sent_idx), 64'(frame_len));
        check("beats_out", 64'(out_count), 64'(n_exp));
        check("idle_after", 64'(ap_idle), 64'd1);
        check("max_value", 64'(max_value), 64'(exp_max));
        check("sync_err", 64'(sync_err), 64'(exp_sync));
    endtask

    task automatic bad_cfg(input int cols, rows, x0, y0, w, h);
        @(negedge clk);
        cfg_in_cols = CW'(cols);
        cfg_in_rows = RW'(rows);
        cfg_x0      = CW'(x0);
        cfg_y0      = RW'(y0);
        cfg_w       = CW'(w);
        cfg_h       = RW'(h);
        ap_start    = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        #1;
        check("cfg_err_pulse", 64'(cfg_err), 64'd1);
        check("cfg_err_idle", 64'(ap_idle), 64'd1);
        check("cfg_err_tready", 64'(s_if.tready), 64'd0);
        @(negedge clk);
        #1;
        check("cfg_err_clear", 64'(cfg_err), 64'd0);
        check("cfg_err_still_idle", 64'(ap_idle), 64'd1);
    endtask

    initial begin
        int cols, rows, w, h, x0, y0;
        reset       = 1'b1;
        ap_start    = 1'b0;
        cfg_in_cols = '0;
        cfg_in_rows = '0;
        cfg_x0      = '0;
        cfg_y0      = '0;
        cfg_w       = '0;
        cfg_h       = '0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        s_fire      = 1'b0;
        held_stall  = 1'b0;
        frame_len   = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_idle", 64'(ap_idle), 64'd1);
        check("rst_done", 64'(ap_done), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        check("rst_sync_err", 64'(sync_err), 64'd0);
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_m_tdata", 64'(m_if.tdata), 64'd0);
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_max", 64'(max_value), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Case 1: ramp frame, no backpressure
        build_frame(32, 0);
        run_frame(16, 8, 4, 2, 8, 3, 0, 0);

        // Case 2: same frame under random backpressure and input gaps
        build_frame(32, 0);
        run_frame(16, 8, 4, 2, 8, 3, 50, 30);

        // Case 3: misaligned / out-of-range / empty configs
        bad_cfg(16, 8, 2, 2, 8, 3);
        bad_cfg(16, 8, 12, 2, 8, 3);
        bad_cfg(16, 8, 4, 2, 0, 3);
        bad_cfg(16, 8, 4, 6, 8, 3);

        // Case 4: single peak pixel inside the crop, then cleared by next start
        build_frame(32, 2);
        in_data[(2 * 16 + 4) / PPB][2*PBW +: PBW] = 10'd1023;
        run_frame(16, 8, 4, 2, 8, 3, 20, 10);

        // Case 5: stray SOF at row 3 col 8, followed by a complete fresh frame
        build_frame(46, 1);
        in_user[14][0] = 1'b1;
        run_frame(16, 8, 4, 2, 8, 3, 30, 20);

        // Boundaries: full-frame crop and bottom-right single beat
        build_frame(24, 1);
        run_frame(16, 6, 0, 0, 16, 6, 40, 0);
        build_frame(24, 1);
        run_frame(16, 6, 12, 5, 4, 1, 0, 40);

        // Randomised configurations
        for (int t = 0; t < 6; t++) begin
            cols = PPB * $urandom_range(1, 8);
            rows = $urandom_range(1, 6);
            w    = PPB * $urandom_range(1, cols / PPB);
            x0   = PPB * $urandom_range(0, (cols - w) / PPB);
            h    = $urandom_range(1, rows);
            y0   = $urandom_range(0, rows - h);
            build_frame(cols * rows / PPB, 1);
            run_frame(cols, rows, x0, y0, w, h, $urandom_range(0, 60), $urandom_range(0, 40));
        end

        // Case 6: reset in the middle of a frame
        build_frame(32, 1);
        compute_expected(16, 8, 0, 0, 16, 8);
        stall_pct  = 30;
        gap_pct    = 0;
        sent_idx   = 0;
        done_count = 0;
        out_count  = 0;
        s_fire     = 1'b0;
        held_stall = 1'b0;
        start_frame(16, 8, 0, 0, 16, 8);
        repeat (10) step();
        @(negedge clk);
        reset       = 1'b1;
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_idle", 64'(ap_idle), 64'd1);
        check("midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("midrst_done", 64'(ap_done), 64'd0);
        check("midrst_s_tready", 64'(s_if.tready), 64'd0);
        @(negedge clk);
        reset      = 1'b0;
        frame_len  = 0;
        s_fire     = 1'b0;
        held_stall = 1'b0;
        exp_q.delete();
        done_count = 0;
        repeat (5) step();
        check("midrst_no_done", 64'(done_count), 64'd0);

        // Recovery after the aborted frame
        build_frame(32, 0);
        run_frame(16, 8, 4, 2, 8, 3, 25, 25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
